alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised ALU for the Armv4 datapath; successor to the single-cycle combinational ALU. Executes the full 16-entry data-processing opcode set plus MUL/MLA (iterative shift-add) under a start/done handshake. Holds the architectural NZCV flags in an internal register, so ADC/SBC/RSC see the true carry-in. Sits between the register-file read stage and the writeback mux; the controller stalls on `busy`.

## Interface
- `WIDTH`, 32, datapath width in bits (≥ 4).
- `CW`, 6, multiply iteration counter width; must satisfy 2^CW > WIDTH.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch an operation; sampled only when `busy`=0.
- `alucontrol`  in  9  {mul, 2'b00, I, cmd[3:0], S}; `I` is ignored.
- `srca`, `srcb`, `srcc`  in  WIDTH each  operands; `srcc` is the MLA accumulator.
- `busy`  out  1  high while a multiply iterates.
- `done`  out  1  one-cycle pulse; `aluresult`, `result_we` and `illegal` are valid in the same cycle.
- `aluresult`  out  WIDTH  registered result; held until the next `done`.
- `result_we`  out  1  0 for TST/TEQ/CMP/CMN and for illegal ops, else 1.
- `illegal`  out  1  pulses with `done` for an undefined encoding.
- `aluflags`  out  4  registered {N,Z,C,V}.

## Operation
- `mul`=0, cmd: 0 AND, 1 EOR, 2 SUB (a−b), 3 RSB (b−a), 4 ADD, 5 ADC, 6 SBC (a−b−!C), 7 RSC (b−a−!C), 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV (b), E BIC (a&~b), F MVN (~b).
- `mul`=1: cmd 0 MUL (a*b), cmd 1 MLA (a*b+c). Any other cmd is illegal.
- Arithmetic is done in WIDTH+1 bits; the result is the low WIDTH bits.
- C is the carry-out. For SUB, RSB, SBC, RSC and CMP, C = NOT borrow.
- V is set when both operands, as presented to the adder, have the same sign and the sum's sign differs.
- Flags update only when S=1; TST/TEQ/CMP/CMN always update flags.
  - Arithmetic ops: write N, Z, C, V.
  - Logical, MOV, MVN, MUL, MLA: write N and Z only; C and V are held.
- Illegal encoding: `aluresult` becomes 0 and flags are unchanged.
- Multiplier:
  - Product register starts at `srcc` (MLA) or 0 (MUL); the multiplicand is `srca`.
  - Each cycle, the shifted `srcb` LSB conditionally adds the left-shifted multiplicand.
  - The product is truncated to WIDTH bits.
- FSM:
  - IDLE: on `start` with `mul`=0, go to DONE. On `start` with a legal multiply, go to MUL with counter = 0. On `start` with an illegal multiply, go to DONE.
  - MUL: counter increments every cycle; `busy`=1. When counter = WIDTH−1, go to DONE.
  - DONE: `done`=1 and `busy`=0 for one cycle, then go to IDLE. A `start` in DONE is ignored.
- Operands and `alucontrol` are captured at the accepting edge; later input changes have no effect.
- `start` while `busy`=1 is ignored and not queued.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `aluresult`=0, `result_we`=0, `illegal`=0, `aluflags`=4'b0000, counter 0.
- A reset asserted mid-multiply aborts the operation. No `done` is produced and the flags are not updated.
- Non-multiply op:
  - `start` accepted at edge N; `done`, result and flags are visible after edge N+1.
  - Latency 1; maximum throughput one op per 2 cycles.
- Multiply op:
  - `busy` is high from after edge N until edge N+WIDTH.
  - `done`, result and flags are visible after edge N+WIDTH+1.
  - Latency WIDTH+1; 33 for WIDTH=32.
- The carry-in for ADC/SBC/RSC is the flag value at the accepting edge. Back-to-back dependent ops therefore see updated flags.

## Test plan
- Reset, then ADDS 0x7FFFFFFF + 0x00000001 → one cycle later `done`=1, `aluresult`=0x80000000, NZCV=1001, `result_we`=1.
- SUBS 5 − 5, then CMP 3, 5 → first op gives 0 with NZCV=0110. CMP gives `result_we`=0 and NZCV=1000 (borrow, so C=0).
- Set C via SUBS 5 − 5, then ADC 1 + 2 with S=0 → result 4, flags stay 0110. Then SBC 10 − 3 → 7.
- MULS 0x0000FFFF × 0x00010001 → `busy` high for 32 cycles, `done` at cycle 33, result 0xFFFFFFFF, N=1, Z=0, C and V unchanged. MLAS with the same operands and `srcc`=1 → 0, Z=1.
- `start` pulsed during `busy` with ADD 1, 1 → ignored: exactly one `done`, carrying the multiply result. `alucontrol`=mul, cmd 5 → `illegal`=1, result 0, flags held.
- `reset` at cycle 10 of a multiply → `busy`=0 and `aluflags`=0 next cycle, no `done`. A following ADDS 1 + 1 completes normally with result 2.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the Armv4 datapath.
// Executes the 16 data-processing opcodes in one cycle and MUL/MLA by an
// iterative shift-add multiplier, under a start/done handshake. The NZCV
// flags live here so ADC/SBC/RSC see the true architectural carry.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [8:0]       alucontrol,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic [WIDTH-1:0] srcc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] aluresult,
   output logic             result_we,
   output logic             illegal,
   output logic [3:0]       aluflags
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } state_t;

   // alucontrol layout: {mul, 2'b00, I, cmd[3:0], S}
   localparam int CTL_MUL = 8;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;       // operand a; doubles as the shifting multiplicand
   logic [WIDTH-1:0] r_b;       // operand b; doubles as the shifting multiplier
   logic [WIDTH-1:0] r_prod;
   logic             r_mul;
   logic [3:0]       r_cmd;
   logic             r_s;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic             r_we;
   logic             r_illegal;
   logic [3:0]       r_flags;   // {N, Z, C, V}

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_cin;
   logic             w_arith;
   logic [WIDTH-1:0] w_logic;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_v;
   logic             w_test;
   logic             w_mul_illegal;
   logic             w_mul_legal_in;
   logic [2:0]       w_unused_ctl;

   // The zero bits and the immediate flag do not affect execution.
   assign w_unused_ctl = alucontrol[7:5];

   // Route operands to the shared adder, or pick the logical result.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case
      // can leave a latch behind.
      w_x     = r_a;
      w_y     = r_b;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      w_logic = '0;
      case (r_cmd)
         4'h0, 4'h8: w_logic = r_a & r_b;                 // AND, TST
         4'h1, 4'h9: w_logic = r_a ^ r_b;                 // EOR, TEQ
         4'h2, 4'hA: begin                                // SUB, CMP
            w_y     = ~r_b;
            w_cin   = 1'b1;
            w_arith = 1'b1;
         end
         4'h3: begin                                      // RSB
            w_x     = r_b;
            w_y     = ~r_a;
            w_cin   = 1'b1;
            w_arith = 1'b1;
         end
         4'h4, 4'hB: w_arith = 1'b1;                      // ADD, CMN
         4'h5: begin                                      // ADC
            w_cin   = r_flags[1];
            w_arith = 1'b1;
         end
         4'h6: begin                                      // SBC: a + ~b + C
            w_y     = ~r_b;
            w_cin   = r_flags[1];
            w_arith = 1'b1;
         end
         4'h7: begin                                      // RSC: b + ~a + C
            w_x     = r_b;
            w_y     = ~r_a;
            w_cin   = r_flags[1];
            w_arith = 1'b1;
         end
         4'hC: w_logic = r_a | r_b;                       // ORR
         4'hD: w_logic = r_b;                             // MOV
         4'hE: w_logic = r_a & ~r_b;                      // BIC
         4'hF: w_logic = ~r_b;                            // MVN
      endcase
   end

   // The carry out of the extra top bit is C; for subtracts it is NOT borrow.
   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
   assign w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;
   assign w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

   assign w_test         = (r_cmd[3:2] == 2'b10);                 // TST/TEQ/CMP/CMN
   assign w_mul_illegal  = r_mul && (r_cmd[3:1] != 3'b000);
   assign w_mul_legal_in = alucontrol[CTL_MUL] && (alucontrol[4:2] == 3'b000);

   // Control FSM, multiplier datapath and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the operand and product registers are deliberately not reset;
         // they are always loaded at the accepting edge before anything reads them.
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_we      <= 1'b0;
         r_illegal <= 1'b0;
         r_flags   <= 4'b0000;
         r_mul     <= 1'b0;
         r_cmd     <= 4'h0;
         r_s       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees its neighbours' pre-edge values regardless of statement order.
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a    <= srca;
                  r_b    <= srcb;
                  r_mul  <= alucontrol[CTL_MUL];
                  r_cmd  <= alucontrol[4:1];
                  r_s    <= alucontrol[0];
                  r_prod <= (alucontrol[4:1] == 4'h1) ? srcc : '0;
                  r_cnt  <= '0;
                  if (w_mul_legal_in) begin
                     r_state <= ST_MUL;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                  end
               end
            end

            ST_MUL: begin
               if (r_b[0]) begin
                  r_prod <= r_prod + r_a;
               end
               r_a   <= r_a << 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
               end
            end

            ST_DONE: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
               if (w_mul_illegal) begin
                  r_result  <= '0;
                  r_we      <= 1'b0;
                  r_illegal <= 1'b1;
               end else if (r_mul) begin
                  r_result <= r_prod;
                  r_we     <= 1'b1;
                  if (r_s) begin
                     r_flags[3:2] <= {r_prod[WIDTH-1], (r_prod == '0)};
                  end
               end else begin
                  r_result <= w_res;
                  r_we     <= ~w_test;
                  if (r_s || w_test) begin
                     r_flags[3:2] <= {w_res[WIDTH-1], (w_res == '0)};
                     if (w_arith) begin
                        r_flags[1:0] <= {w_sum[WIDTH], w_v};
                     end
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign aluresult = r_result;
   assign result_we = r_we;
   assign illegal   = r_illegal;
   assign aluflags  = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc. The stimulus process computes the
// expected response from an integer-arithmetic model and queues it; a monitor
// pops and compares whenever the DUT pulses done.
module tb_alu_mc;

   localparam int WIDTH = 32;
   localparam int CW    = 6;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [8:0]       alucontrol;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic [WIDTH-1:0] srcc;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] aluresult;
   logic             result_we;
   logic             illegal;
   logic [3:0]       aluflags;

   typedef struct {
      logic [31:0] res;
      logic        we;
      logic        ill;
      logic [3:0]  flags;
   } exp_t;

   exp_t       q[$];
   int         n_vec  = 0;
   int         n_fail = 0;
   logic [3:0] m_flags;
   int         busy_cnt;

   alu_mc #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .alucontrol (alucontrol),
      .srca       (srca),
      .srcb       (srcb),
      .srcc       (srcc),
      .busy       (busy),
      .done       (done),
      .aluresult  (aluresult),
      .result_we  (result_we),
      .illegal    (illegal),
      .aluflags   (aluflags)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] ctl(input logic m, input logic [3:0] cmd, input logic s);
      return {m, 2'b00, 1'b0, cmd, s};
   endfunction

   // Reference model: exact integer arithmetic, flags derived from the rules.
   function automatic exp_t model(input logic [8:0] c, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] acc,
                                  input logic [3:0] f);
      exp_t        e;
      logic [3:0]  cmd;
      logic        s;
      longint      ua, ub, sa, sb, u, sv, cin;
      logic [63:0] p;
      bit          arith, sub, test;
      cmd   = c[4:1];
      s     = c[0];
      ua    = longint'({32'h0, a});
      ub    = longint'({32'h0, b});
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      cin   = f[1] ? 64'sd1 : 64'sd0;
      u     = 0;
      sv    = 0;
      e.flags = f;
      e.ill   = 1'b0;
      e.we    = 1'b1;
      e.res   = 32'h0;
      if (c[8]) begin
         if (cmd > 4'd1) begin
            e.ill = 1'b1;
            e.we  = 1'b0;
            return e;
         end
         p = {32'h0, a} * {32'h0, b} + ((cmd == 4'd1) ? {32'h0, acc} : 64'h0);
         e.res = p[31:0];
         if (s) begin
            e.flags[3] = e.res[31];
            e.flags[2] = (e.res == 32'h0);
         end
         return e;
      end
      arith = (cmd inside {[4'h2:4'h7], 4'hA, 4'hB});
      sub   = (cmd inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA});
      test  = (cmd inside {[4'h8:4'hB]});
      case (cmd)
         4'h0, 4'h8: e.res = a & b;
         4'h1, 4'h9: e.res = a ^ b;
         4'hC:       e.res = a | b;
         4'hD:       e.res = b;
         4'hE:       e.res = a & ~b;
         4'hF:       e.res = ~b;
         4'h2, 4'hA: begin u = ua - ub;             sv = sa - sb;             end
         4'h3:       begin u = ub - ua;             sv = sb - sa;             end
         4'h4, 4'hB: begin u = ua + ub;             sv = sa + sb;             end
         4'h5:       begin u = ua + ub + cin;       sv = sa + sb + cin;       end
         4'h6:       begin u = ua - ub - (1 - cin); sv = sa - sb - (1 - cin); end
         4'h7:       begin u = ub - ua - (1 - cin); sv = sb - sa - (1 - cin); end
      endcase
      if (arith) e.res = u[31:0];
      e.we = !test;
      if (s || test) begin
         e.flags[3] = e.res[31];
         e.flags[2] = (e.res == 32'h0);
         if (arith) begin
            e.flags[1] = sub ? (u >= 0) : (u >= (64'sd1 <<< 32));
            e.flags[0] = (sv > SMAX) || (sv < SMIN);
         end
      end
      return e;
   endfunction

   function automatic logic [31:0] rnd_opd();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accepting edge.
   task automatic launch(input logic [8:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] acc);
      exp_t e;
      e = model(c, a, b, acc, m_flags);
      m_flags = e.flags;
      q.push_back(e);
      alucontrol = c;
      srca       = a;
      srcb       = b;
      srcc       = acc;
      start      = 1'b1;
      @(posedge clock);
      #1;
      start      = 1'b0;
      alucontrol = 9'($urandom);
      srca       = 32'($urandom);
      srcb       = 32'($urandom);
      srcc       = 32'($urandom);
      busy_cnt   = (busy === 1'b1) ? 1 : 0;
   endtask

   task automatic finish_op(input int exp_lat, input int exp_busy, input int cyc0);
      int cyc;
      cyc = cyc0;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clock);
         #1;
         cyc++;
         if (busy === 1'b1) busy_cnt++;
      end
      if (done !== 1'b1) begin
         check("done_timeout", 64'd0, 64'd1);
      end else begin
         check("latency", 64'(cyc), 64'(exp_lat));
         check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
      end
   endtask

   task automatic do_op(input logic [8:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] acc);
      bit is_mul;
      is_mul = c[8] && (c[4:1] < 4'd2);
      launch(c, a, b, acc);
      finish_op(is_mul ? WIDTH + 1 : 1, is_mul ? WIDTH : 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      exp_t e;
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            check("result",    64'(aluresult), 64'(e.res));
            check("result_we", 64'(result_we), 64'(e.we));
            check("illegal",   64'(illegal),   64'(e.ill));
            check("flags",     64'(aluflags),  64'(e.flags));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      alucontrol = 9'h0;
      srca       = 32'h0;
      srcb       = 32'h0;
      srcc       = 32'h0;
      m_flags    = 4'b0000;
      busy_cnt   = 0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_done",      64'(done),      64'd0);
      check("rst_result",    64'(aluresult), 64'd0);
      check("rst_result_we", 64'(result_we), 64'd0);
      check("rst_illegal",   64'(illegal),   64'd0);
      check("rst_flags",     64'(aluflags),  64'd0);
      reset = 1'b0;
      idle(1);

      // Directed cases.
      do_op(ctl(1'b0, 4'h4, 1'b1), 32'h7FFF_FFFF, 32'h0000_0001, 32'h0);   // ADDS overflow
      do_op(ctl(1'b0, 4'h2, 1'b1), 32'd5, 32'd5, 32'h0);                   // SUBS 5-5
      do_op(ctl(1'b0, 4'hA, 1'b0), 32'd3, 32'd5, 32'h0);                   // CMP 3,5
      do_op(ctl(1'b0, 4'h2, 1'b1), 32'd5, 32'd5, 32'h0);                   // set C
      do_op(ctl(1'b0, 4'h5, 1'b0), 32'd1, 32'd2, 32'h0);                   // ADC -> 4
      do_op(ctl(1'b0, 4'h6, 1'b0), 32'd10, 32'd3, 32'h0);                  // SBC -> 7
      do_op(ctl(1'b1, 4'h0, 1'b1), 32'h0000_FFFF, 32'h0001_0001, 32'h0);   // MULS
      do_op(ctl(1'b1, 4'h1, 1'b1), 32'h0000_FFFF, 32'h0001_0001, 32'h1);   // MLAS -> 0

      // A start during busy must be ignored.
      launch(ctl(1'b1, 4'h0, 1'b0), 32'h0000_1234, 32'h0000_5678, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         if (busy === 1'b1) busy_cnt++;
      end
      alucontrol = ctl(1'b0, 4'h4, 1'b1);
      srca       = 32'd1;
      srcb       = 32'd1;
      start      = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      finish_op(WIDTH + 1, WIDTH, 5);
      idle(4);

      // Undefined multiply encoding.
      do_op(ctl(1'b1, 4'h5, 1'b1), 32'h1111_2222, 32'h3333_4444, 32'h5);

      // A start in the DONE cycle must be ignored.
      launch(ctl(1'b0, 4'h4, 1'b1), 32'd100, 32'd23, 32'h0);
      alucontrol = ctl(1'b0, 4'h4, 1'b1);
      srca       = 32'd5;
      srcb       = 32'd5;
      start      = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      finish_op(1, 0, 1);
      idle(3);

      // Reset in the middle of a multiply aborts it.
      launch(ctl(1'b1, 4'h0, 1'b1), 32'h0000_FFFF, 32'h0001_0001, 32'h0);
      idle(9);
      reset = 1'b1;
      q.delete();
      m_flags = 4'b0000;
      @(posedge clock);
      #1;
      check("abort_busy",  64'(busy),     64'd0);
      check("abort_flags", 64'(aluflags), 64'd0);
      check("abort_done",  64'(done),     64'd0);
      reset = 1'b0;
      idle(40);
      do_op(ctl(1'b0, 4'h4, 1'b1), 32'd1, 32'd1, 32'h0);                   // ADDS 1+1

      // Randomised operations.
      for (int i = 0; i < 60; i++) begin
         logic [8:0] c;
         c = {($urandom_range(0, 3) == 0), 2'b00, 1'($urandom), 4'($urandom), 1'($urandom)};
         if (c[8]) c[4:1] = 4'($urandom_range(0, 2)) == 4'd2 ? 4'($urandom_range(2, 15))
                                                             : 4'($urandom_range(0, 1));
         do_op(c, rnd_opd(), rnd_opd(), rnd_opd());
      end

      idle(3);
      check("queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
